// File: rtl/mvm_noc_pkg.sv
// Shared constants and payload types for the MVM NoC instruction path.
package mvm_noc_pkg;

    localparam int unsigned USER_TYPE_LSB = 9;
    localparam int unsigned INSTW         = 32;
    localparam int unsigned ENTRY_DESTW   = 4;

    localparam logic [1:0] TYPE_INST   = 2'b00;
    localparam logic [1:0] TYPE_WEIGHT = 2'b11;

    typedef struct packed {
        logic                   last;
        logic [ENTRY_DESTW-1:0] dest;
        logic [INSTW-1:0]       word;
    } inst_entry_t;

endpackage

// File: rtl/inst_loader_if.sv
// AXI-Stream transmit bundle from the instruction loader into its mesh node.
interface inst_loader_if #(
    parameter int unsigned DATAW = 512,
    parameter int unsigned USERW = 75,
    parameter int unsigned IDW   = 2,
    parameter int unsigned DESTW = 4
);
    logic                   tvalid;
    logic                   tready;
    logic [DATAW+USERW-1:0] tdata;
    logic [IDW-1:0]         tid;
    logic [DESTW-1:0]       tdest;
    logic                   tlast;

    modport master (output tvalid, tdata, tid, tdest, tlast, input tready);
    modport slave  (input tvalid, tdata, tid, tdest, tlast, output tready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and registered ready/valid flags.
module sync_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_rdy,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             rd_vld
);
    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [CNTW-1:0]  count;
    logic [CNTW-1:0]  count_d;
    logic             wr_fire_c;
    logic             rd_fire_c;

    assign wr_fire_c = wr_en && wr_rdy;
    assign rd_fire_c = rd_en && rd_vld;
    assign rd_data_c = mem[rd_ptr];

    // Next occupancy; flags are registered from it so full never passes through.
    always_comb begin
        count_d = count;
        if (wr_fire_c && !rd_fire_c) begin
            count_d = count + CNTW'(1);
        end else if (!wr_fire_c && rd_fire_c) begin
            count_d = count - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wr_rdy <= 1'b1;
            rd_vld <= 1'b0;
        end else begin
            if (wr_fire_c) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (rd_fire_c) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            count  <= count_d;
            wr_rdy <= (count_d != CNTW'(DEPTH));
            rd_vld <= (count_d != CNTW'(0));
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Buffers destination-tagged instruction words and injects them into the NoC
// as single-beat-per-word AXI-Stream packets, with packet tracking and stats.
module inst_loader
    import mvm_noc_pkg::*;
#(
    parameter int unsigned DATAW      = 512,
    parameter int unsigned USERW      = 75,
    parameter int unsigned IDW        = 2,
    parameter int unsigned DESTW      = 4,
    parameter int unsigned TID        = 0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_fifo_wen,
    input  logic [INSTW-1:0]   inst_fifo_wdata,
    input  logic [DESTW-1:0]   inst_fifo_wdest,
    input  logic               inst_fifo_wlast,
    output logic               inst_fifo_rdy,
    inst_loader_if.master      axis_tx,
    output logic [15:0]        inst_sent,
    output logic [15:0]        pkt_sent,
    output logic               ovf_err,
    output logic               dest_err
);
    localparam int unsigned    ENTW       = $bits(inst_entry_t);
    localparam logic [USERW-1:0] USER_FIELD = USERW'(TYPE_INST) << USER_TYPE_LSB;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_PKT = 1'b1;

    inst_entry_t      wr_entry_c;
    inst_entry_t      head_c;
    inst_entry_t      beat_q;
    logic [ENTW-1:0]  head_bits_c;
    logic             fifo_rd_vld;
    logic             load_c;
    logic             accept_c;
    logic             tvalid_q;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [DESTW-1:0] pkt_dest_q;
    logic [DESTW-1:0] pkt_dest_d;
    logic             dest_err_d;

    assign wr_entry_c = '{last: inst_fifo_wlast,
                          dest: ENTRY_DESTW'(inst_fifo_wdest),
                          word: inst_fifo_wdata};
    assign head_c     = inst_entry_t'(head_bits_c);

    sync_fifo #(
        .WIDTH (ENTW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (inst_fifo_wen),
        .wr_data   (wr_entry_c),
        .wr_rdy    (inst_fifo_rdy),
        .rd_en     (load_c),
        .rd_data_c (head_bits_c),
        .rd_vld    (fifo_rd_vld)
    );

    // Output beat refills when empty or when its current beat leaves this cycle.
    assign accept_c = tvalid_q && axis_tx.tready;
    assign load_c   = fifo_rd_vld && (!tvalid_q || axis_tx.tready);

    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid_q <= 1'b0;
            beat_q   <= '0;
        end else if (load_c) begin
            tvalid_q <= 1'b1;
            beat_q   <= head_c;
        end else if (accept_c) begin
            tvalid_q <= 1'b0;
        end
    end

    assign axis_tx.tvalid = tvalid_q;
    assign axis_tx.tdata  = {USER_FIELD, {(DATAW-INSTW){1'b0}}, beat_q.word};
    assign axis_tx.tid    = IDW'(TID);
    assign axis_tx.tdest  = DESTW'(beat_q.dest);
    assign axis_tx.tlast  = beat_q.last;

    // Packet tracker: flags any beat whose dest differs from the packet's first beat.
    always_comb begin
        state_d    = state_q;
        pkt_dest_d = pkt_dest_q;
        dest_err_d = dest_err;
        if (accept_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (!beat_q.last) begin
                        state_d    = ST_IN_PKT;
                        pkt_dest_d = DESTW'(beat_q.dest);
                    end
                end
                ST_IN_PKT: begin
                    if (DESTW'(beat_q.dest) != pkt_dest_q) begin
                        dest_err_d = 1'b1;
                    end
                    if (beat_q.last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pkt_dest_q <= '0;
            dest_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pkt_dest_q <= pkt_dest_d;
            dest_err   <= dest_err_d;
        end
    end

    // Statistics wrap silently; overflow flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_sent <= '0;
            pkt_sent  <= '0;
            ovf_err   <= 1'b0;
        end else begin
            if (accept_c) begin
                inst_sent <= inst_sent + 16'd1;
            end
            if (accept_c && beat_q.last) begin
                pkt_sent <= pkt_sent + 16'd1;
            end
            if (inst_fifo_wen && !inst_fifo_rdy) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: stimulus pushes expected beats, a negedge
// monitor pops and compares whenever a beat is handed off downstream.
module tb_inst_loader;
    localparam int unsigned DATAW = 512;
    localparam int unsigned USERW = 75;
    localparam int unsigned IDW   = 2;
    localparam int unsigned DESTW = 4;
    localparam int unsigned TDW   = DATAW + USERW;

    typedef struct {
        logic [31:0] w;
        logic [3:0]  d;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_fifo_wen = 1'b0;
    logic [31:0] inst_fifo_wdata = '0;
    logic [3:0]  inst_fifo_wdest = '0;
    logic        inst_fifo_wlast = 1'b0;
    logic        inst_fifo_rdy;
    logic [15:0] inst_sent;
    logic [15:0] pkt_sent;
    logic        ovf_err;
    logic        dest_err;

    inst_loader_if #(.DATAW(DATAW), .USERW(USERW), .IDW(IDW), .DESTW(DESTW)) axis_tx ();

    inst_loader dut (
        .clk             (clk),
        .rst             (rst),
        .inst_fifo_wen   (inst_fifo_wen),
        .inst_fifo_wdata (inst_fifo_wdata),
        .inst_fifo_wdest (inst_fifo_wdest),
        .inst_fifo_wlast (inst_fifo_wlast),
        .inst_fifo_rdy   (inst_fifo_rdy),
        .axis_tx         (axis_tx),
        .inst_sent       (inst_sent),
        .pkt_sent        (pkt_sent),
        .ovf_err         (ovf_err),
        .dest_err        (dest_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        q[$];
    logic [15:0] exp_inst = '0;
    logic [15:0] exp_pkt  = '0;
    logic        exp_derr = 1'b0;
    logic        exp_ovf  = 1'b0;
    bit          pkt_open = 1'b0;
    logic [3:0]  pkt_dest = '0;

    task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: record the beat and apply packet-level rules to the flags.
    task automatic push(input logic [31:0] w, input logic [3:0] d, input logic l);
        exp_t e;
        e.w = w; e.d = d; e.l = l;
        q.push_back(e);
        exp_inst = exp_inst + 16'd1;
        if (l) exp_pkt = exp_pkt + 16'd1;
        if (!pkt_open) begin
            if (!l) begin
                pkt_open = 1'b1;
                pkt_dest = d;
            end
        end else begin
            if (d != pkt_dest) exp_derr = 1'b1;
            if (l) pkt_open = 1'b0;
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_inst = '0; exp_pkt = '0; exp_derr = 1'b0; exp_ovf = 1'b0;
        pkt_open = 1'b0;
    endtask

    task automatic wr(input logic [31:0] w, input logic [3:0] d, input logic l, input bit acc);
        inst_fifo_wen   = 1'b1;
        inst_fifo_wdata = w;
        inst_fifo_wdest = d;
        inst_fifo_wlast = l;
        if (acc) push(w, d, l);
        @(posedge clk); #1;
        inst_fifo_wen = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        axis_tx.tready = 1'b1;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        idle(2);
        chk({nm, "_drained"},   32'(q.size()), 32'd0);
        chk({nm, "_inst_sent"}, inst_sent, exp_inst);
        chk({nm, "_pkt_sent"},  pkt_sent, exp_pkt);
        chk({nm, "_dest_err"},  dest_err, exp_derr);
        chk({nm, "_ovf_err"},   ovf_err, exp_ovf);
        chk({nm, "_rdy"},       inst_fifo_rdy, 1'b1);
        chk({nm, "_tvalid"},    axis_tx.tvalid, 1'b0);
    endtask

    // Monitor: stability under stall and in-order scoreboard comparison.
    logic           stall_prev = 1'b0;
    logic [TDW-1:0] td_prev;
    logic [3:0]     dest_prev;
    logic           last_prev;

    always @(negedge clk) begin
        exp_t           e;
        logic [TDW-1:0] exp_td;
        if (!rst && stall_prev) begin
            chk("stall_tvalid", axis_tx.tvalid, 1'b1);
            chk("stall_tdata",  axis_tx.tdata, td_prev);
            chk("stall_tdest",  axis_tx.tdest, dest_prev);
            chk("stall_tlast",  axis_tx.tlast, last_prev);
        end
        stall_prev = !rst && axis_tx.tvalid && !axis_tx.tready;
        td_prev    = axis_tx.tdata;
        dest_prev  = axis_tx.tdest;
        last_prev  = axis_tx.tlast;
        if (!rst && axis_tx.tvalid && axis_tx.tready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got word %0h with nothing expected", axis_tx.tdata[31:0]);
            end else begin
                e = q.pop_front();
                exp_td = '0;
                exp_td[31:0] = e.w;
                exp_td[DATAW+9 +: 2] = 2'b00;
                chk("beat_tdata", axis_tx.tdata, exp_td);
                chk("beat_tdest", axis_tx.tdest, e.d);
                chk("beat_tlast", axis_tx.tlast, e.l);
                chk("beat_tid",   axis_tx.tid, 2'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [3:0]  d;
        axis_tx.tready = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid",    axis_tx.tvalid, 1'b0);
        chk("rst_tdata",     axis_tx.tdata, '0);
        chk("rst_tdest",     axis_tx.tdest, 4'd0);
        chk("rst_tlast",     axis_tx.tlast, 1'b0);
        chk("rst_rdy",       inst_fifo_rdy, 1'b1);
        chk("rst_inst_sent", inst_sent, 16'd0);
        chk("rst_pkt_sent",  pkt_sent, 16'd0);
        chk("rst_ovf",       ovf_err, 1'b0);
        chk("rst_derr",      dest_err, 1'b0);

        // Three-word packet: latency and back-to-back beats
        @(posedge clk); #1;
        axis_tx.tready = 1'b1;
        fork
            begin
                wr(32'h11, 4'd3, 1'b0, 1'b1);
                wr(32'h22, 4'd3, 1'b0, 1'b1);
                wr(32'h33, 4'd3, 1'b1, 1'b1);
            end
            begin
                @(posedge clk);
                @(negedge clk); chk("lat_cycle1_tvalid", axis_tx.tvalid, 1'b0);
                @(negedge clk); chk("lat_cycle2_tvalid", axis_tx.tvalid, 1'b1);
                @(negedge clk); chk("b2b_beat2_tvalid", axis_tx.tvalid, 1'b1);
                @(negedge clk); chk("b2b_beat3_tvalid", axis_tx.tvalid, 1'b1);
            end
        join
        drain("three");
        chk("three_inst_3", inst_sent, 16'd3);
        chk("three_pkt_1",  pkt_sent, 16'd1);

        // Overflow: 17 words fit (16 FIFO + 1 output), the 18th is dropped
        axis_tx.tready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            w = $urandom;
            wr(w, 4'd7, (i == 17), 1'b1);
            chk($sformatf("ovf_rdy_after_%0d", i), inst_fifo_rdy, (i < 17));
        end
        chk("ovf_head_word", axis_tx.tdata[31:0], q[0].w);
        chk("ovf_flag_before", ovf_err, 1'b0);
        wr(32'hDEAD_BEEF, 4'd7, 1'b1, 1'b0);
        exp_ovf = 1'b1;
        idle(1);
        chk("ovf_flag_after", ovf_err, 1'b1);
        chk("ovf_pending_17", 32'(q.size()), 32'd17);
        drain("ovf");

        // Ready toggling every cycle during a 10-word packet
        d = 4'($urandom_range(0, 15));
        fork
            begin
                for (int i = 0; i < 10; i++) wr($urandom, d, (i == 9), 1'b1);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    axis_tx.tready = (i % 2 == 0);
                    @(posedge clk); #1;
                end
            end
        join
        drain("toggle");

        // Destination change inside a packet
        wr(32'hA1, 4'd3, 1'b0, 1'b1);
        wr(32'hA2, 4'd4, 1'b0, 1'b1);
        wr(32'hA3, 4'd3, 1'b1, 1'b1);
        drain("destchg");
        chk("destchg_flag", dest_err, 1'b1);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            axis_tx.tready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1 && q.size() < 14)
                wr($urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'b1);
            else
                idle(1);
        end
        drain("random");

        // Reset after 2 of 5 beats of a packet
        axis_tx.tready = 1'b0;
        for (int i = 0; i < 5; i++) wr($urandom, 4'd5, (i == 4), 1'b1);
        idle(1);
        axis_tx.tready = 1'b1;
        idle(2);
        axis_tx.tready = 1'b0;
        chk("midpkt_pending", 32'(q.size()), 32'd3);
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tvalid",    axis_tx.tvalid, 1'b0);
        chk("midrst_inst_sent", inst_sent, 16'd0);
        chk("midrst_pkt_sent",  pkt_sent, 16'd0);
        chk("midrst_rdy",       inst_fifo_rdy, 1'b1);
        chk("midrst_ovf",       ovf_err, 1'b0);
        chk("midrst_derr",      dest_err, 1'b0);
        axis_tx.tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_fifo_empty", axis_tx.tvalid, 1'b0);
        end
        @(posedge clk); #1;

        // Counter wrap: 0xFFFE single-beat packets, then three more
        for (int i = 0; i < 32'hFFFE; i++) wr(32'(i), 4'(i), 1'b1, 1'b1);
        drain("preload");
        chk("preload_fffe", inst_sent, 16'hFFFE);
        for (int i = 0; i < 3; i++) wr($urandom, 4'd2, 1'b1, 1'b1);
        drain("wrap");
        chk("wrap_inst_0001", inst_sent, 16'h0001);
        chk("wrap_pkt_0001",  pkt_sent, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
